// File: rtl/serial_sub_pkg.sv
// Shared types and limits for the bit-serial subtractor.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } serial_sub_state_t;

   localparam int unsigned SERIAL_SUB_MAX_WIDTH = 64;

endpackage

// File: rtl/fsub_bit.sv
// Combinational 1-bit full-subtractor cell: d = a - b - bin, bout = borrow out.
module fsub_bit (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor, diff = a - b - bin, LSB first, one bit per clock.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_sub
   import serial_sub_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   if (WIDTH < 2 || WIDTH > SERIAL_SUB_MAX_WIDTH) begin : g_bad_width
      $error("serial_sub: WIDTH out of range");
   end

   serial_sub_state_t state_q, state_d;
   logic [WIDTH-1:0]  sa_q, sa_d, sb_q, sb_d, sd_q, sd_d;
   logic [WIDTH-1:0]  diff_q, diff_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              br_q, br_d, borrow_q, borrow_d;
   logic              d, bout;
`ifdef SERIAL_SUB_OVF_EN
   logic              ovf_q, ovf_d;
`endif

   fsub_bit u_cell (
      .a   (sa_q[0]),
      .b   (sb_q[0]),
      .bin (br_q),
      .d   (d),
      .bout(bout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         sa_q     <= '0;
         sb_q     <= '0;
         sd_q     <= '0;
         cnt_q    <= '0;
         br_q     <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         sd_q     <= sd_d;
         cnt_q    <= cnt_d;
         br_q     <= br_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      sd_d     = sd_q;
      cnt_d    = cnt_q;
      br_d     = br_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
      ovf_d    = ovf_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (start) begin
               sa_d    = a;
               sb_d    = b;
               br_d    = bin;
               cnt_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            sa_d  = sa_q >> 1;
            sb_d  = sb_q >> 1;
            br_d  = bout;
            sd_d  = {d, sd_q[WIDTH-1:1]};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               diff_d   = {d, sd_q[WIDTH-1:1]};
               borrow_d = bout;
`ifdef SERIAL_SUB_OVF_EN
               // Borrow into the MSB cell differing from borrow out flags signed overflow
               ovf_d    = br_q ^ bout;
`endif
               state_d  = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign busy   = (state_q == StRun);
   assign done   = (state_q == StDone);
   assign diff   = diff_q;
   assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
   assign ovf    = ovf_q;
`endif

endmodule
